lcd_vbuf_writer: RTL and testbench
==================================

Name: lcd_vbuf_writer

Overview:
- Write-side controller for the LCD frame buffer dual-port RAM.
- Sits between the PPU pixel stream (pixel strobe, 15-bit pixel, LCD mode, LCD enable) and the RAM write port.
- Sequences pixel writes into the buffer in raster order and tracks line and frame boundaries.
- Shares the single write port between PPU pixels and an internal clear engine that blanks the buffer when the LCD is switched off, so the scan-out side never shows stale frames.

Parameters:
- W, 160, pixels per line.
- H, 144, lines per frame.
- CLEAR_VALUE, 15'h0000, word written by the clear engine (DMG shade 0 / CGB black).

Ports:
- clk  in  1  system clock, same domain as the PPU.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  pixel strobe; one PPU pixel is valid when high.
- pix_data  in  15  PPU pixel (DMG uses [1:0]; CGB uses RGB555).
- mode  in  2  PPU mode: 00 hblank, 01 vblank, 10 OAM, 11 transfer.
- on  in  1  LCD enable.
- wr_en  out  1  RAM write enable.
- wr_addr  out  16  RAM write address; bit 15 is the bank bit, which is 0 unless LCD_DOUBLE_BUF_EN is defined.
- wr_data  out  15  RAM write data.
- rd_bank  out  1  bank the scan-out side reads; always 0 without LCD_DOUBLE_BUF_EN.
- clearing  out  1  high while the clear engine owns the port.
- frame_done  out  1  one-cycle pulse when a complete frame has been written.
- overflow  out  1  sticky flag: a pixel arrived after W*H pixels in the current frame.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, rd_bank=0, clearing=0, frame_done=0, overflow=0.
  - Internal: x=0, y=0; state=IDLE.
- Internal counters: x (0..W-1) and y (0..H-1). Pixel address = y*W+x, computed with an incrementing line base (add W per line), not a multiplier.
- Outputs are registered: a strobe at cycle n produces wr_en/wr_addr/wr_data at cycle n+1. Latency is 1.
- IDLE:
  - Waits for on=1 and mode!=01. Then x=y=0, state goes to ACTIVE.
  - ce is ignored in IDLE.
- ACTIVE:
  - Each ce with mode!=01 writes pix_data at y*W+x, then advances x. At x=W-1, x wraps to 0 and y increments.
  - After the pixel at (W-1,H-1), state goes to FULL and frame_done pulses on the cycle that pixel's write is issued.
- FULL:
  - Further ce with mode!=01 produces no write and sets overflow=1.
  - overflow stays set until reset or the next rising edge of on.
- Mode 01 entry (rising edge of mode==01, detected from a registered copy of mode):
  - Applies in ACTIVE or FULL: x=y=0, state goes to ACTIVE.
  - A short frame (fewer than W*H pixels) produces no frame_done.
  - ce during mode 01 is ignored.
- on falling in any state other than CLEAR:
  - Enters CLEAR on the next cycle and drops the pixel on that cycle.
  - clearing=1; writes CLEAR_VALUE at addresses 0..W*H-1, one per cycle, with wr_en=1 continuously.
  - After the last address: clearing=0, state goes to IDLE.
- Arbitration in CLEAR: the clear engine has absolute priority and all ce are discarded.
- on rising while in CLEAR: the clear runs to completion, then IDLE immediately re-arms (on=1) and waits for mode!=01.
- on=0 in IDLE after clear completes: no writes.
- wr_data holds its last value when wr_en=0; wr_addr likewise.
- Reset mid-clear: aborts the clear; the buffer contents are unspecified.

Optional Feature:
- LCD_DOUBLE_BUF_EN defined:
  - Two banks. The write bank is ~rd_bank and is placed in wr_addr[15].
  - rd_bank toggles on the cycle after frame_done, so scan-out only ever sees complete frames.
  - CLEAR fills both banks (bank 0 then bank 1, 2*W*H cycles); rd_bank is set to 0 at clear completion.
- LCD_DOUBLE_BUF_EN undefined:
  - Single bank; wr_addr[15]=0 and rd_bank=0 constant.
  - CLEAR takes W*H cycles.

Test Plan:
- Frame write (W=4, H=3, on=1, mode=11): 12 strobes with data 1..12 -> writes addr 0..11 with data 1..12, each one cycle after its strobe; single frame_done with the 12th write; overflow=0.
- Overflow (W=4, H=3): 13th strobe before vblank -> no write; overflow=1; it stays 1 through vblank and clears on the next on rising edge.
- Short frame (W=4, H=3): 5 strobes, then mode->01, then 12 strobes -> second frame restarts at addr 0; exactly one frame_done.
- LCD off mid-line (W=4, H=3): on->0 after 6 pixels -> clearing=1 for 12 cycles writing 0 to addr 0..11; strobes during the clear produce no write; then clearing=0 and no wr_en.
- Async reset (W=4, H=3): reset_n low during clear at addr 5 -> all outputs 0 immediately; after release, on=1/mode=11 and first strobe writes addr 0.
- Double buffer (LCD_DOUBLE_BUF_EN, W=4, H=3): two full frames -> frame 1 has wr_addr[15]=1 and rd_bank toggles 0->1 after frame_done; frame 2 has wr_addr[15]=0 and rd_bank goes 1->0; on->0 -> 24 clear writes, bank 0 then bank 1, rd_bank=0 after completion.

Source files
------------

// File: rtl/lcd_vbuf_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_vbuf_writer_if
//   Bundles the PPU pixel stream and the frame-buffer RAM write port that
//   meet at lcd_vbuf_writer.
//
//   PPU side   : ce (pixel strobe), pix_data[14:0], mode[1:0], on
//   RAM side   : wr_en, wr_addr[15:0] (bit 15 = bank), wr_data[14:0]
//   Status     : rd_bank, clearing, frame_done, overflow
//
//   slave  : used by lcd_vbuf_writer (consumes pixels, drives the RAM port)
//   master : used by whatever drives the PPU stream and observes the port
// ---------------------------------------------------------------------------
interface lcd_vbuf_writer_if;
  logic        ce;
  logic [14:0] pix_data;
  logic [1:0]  mode;
  logic        on;

  logic        wr_en;
  logic [15:0] wr_addr;
  logic [14:0] wr_data;
  logic        rd_bank;
  logic        clearing;
  logic        frame_done;
  logic        overflow;

  modport master (
    output ce, pix_data, mode, on,
    input  wr_en, wr_addr, wr_data, rd_bank, clearing, frame_done, overflow
  );

  modport slave (
    input  ce, pix_data, mode, on,
    output wr_en, wr_addr, wr_data, rd_bank, clearing, frame_done, overflow
  );
endinterface

// File: rtl/lcd_vbuf_writer.sv
// ---------------------------------------------------------------------------
// lcd_vbuf_writer
//   Write-side controller for the LCD frame-buffer dual-port RAM. Places PPU
//   pixels in raster order (address = y*W + x), tracks line/frame
//   boundaries, and blanks the buffer with CLEAR_VALUE whenever the LCD is
//   switched off. The clear engine owns the single write port outright while
//   it runs; pixels arriving meanwhile are discarded.
//
//   Ports:
//     clk      : system clock (PPU domain)
//     reset_n  : asynchronous active-low reset
//     bus      : lcd_vbuf_writer_if.slave
//                in  : ce, pix_data[14:0], mode[1:0], on
//                out : wr_en, wr_addr[15:0], wr_data[14:0], rd_bank,
//                      clearing, frame_done, overflow
//   All outputs are registered; a pixel strobed in cycle n is written in
//   cycle n+1.
//
//   Build option:
//     LCD_DOUBLE_BUF_EN : two banks. Pixels go to bank ~rd_bank (wr_addr[15]),
//                         rd_bank flips the cycle after frame_done, and a
//                         clear blanks bank 0 then bank 1 and leaves
//                         rd_bank = 0. Undefined: single bank, wr_addr[15]
//                         and rd_bank tied to 0.
// ---------------------------------------------------------------------------
module lcd_vbuf_writer #(
  parameter int          W           = 160,
  parameter int          H           = 144,
  parameter logic [14:0] CLEAR_VALUE = 15'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_vbuf_writer_if.slave   bus
);

  localparam int         AW          = 15;
  localparam int         NPIX        = W * H;
  localparam int         XW          = (W > 1) ? $clog2(W) : 1;
  localparam int         YW          = (H > 1) ? $clog2(H) : 1;
  localparam logic [1:0] MODE_VBLANK = 2'b01;
`ifdef LCD_DOUBLE_BUF_EN
  localparam logic       LAST_CLR_BANK = 1'b1;
`else
  localparam logic       LAST_CLR_BANK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  // Sequencer state
  state_t        state_q,    state_d;
  logic [XW-1:0] x_q,        x_d;
  logic [YW-1:0] y_q,        y_d;
  logic [AW-1:0] base_q,     base_d;      // y*W, stepped by W per line
  logic [AW-1:0] clr_cnt_q,  clr_cnt_d;
  logic          clr_bank_q, clr_bank_d;
  logic [1:0]    mode_q;
  logic          on_q;

  // Output registers
  logic          wr_en_q,      wr_en_d;
  logic [15:0]   wr_addr_q,    wr_addr_d;
  logic [14:0]   wr_data_q,    wr_data_d;
  logic          rd_bank_q,    rd_bank_d;
  logic          clearing_q,   clearing_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q,   overflow_d;

  // Events decoded by the next-state logic for the output logic
  logic          pix_wr, last_pix, ovf_hit, clr_wr, clr_done;

  logic          vblank, vblank_rise, on_rise, on_fall;
  logic          wr_bank;
  logic          x_last, y_last;

  assign vblank      = (bus.mode == MODE_VBLANK);
  assign vblank_rise = vblank && (mode_q != MODE_VBLANK);
  assign on_rise     =  bus.on && !on_q;
  assign on_fall     = !bus.on &&  on_q;
  assign x_last      = (x_q == XW'(W - 1));
  assign y_last      = (y_q == YW'(H - 1));

`ifdef LCD_DOUBLE_BUF_EN
  assign wr_bank = ~rd_bank_q;
`else
  assign wr_bank = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register (also holds counters and the edge-detect copies)
  // -------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      clr_cnt_q  <= '0;
      clr_bank_q <= 1'b0;
      mode_q     <= 2'b00;
      on_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_bank_q <= clr_bank_d;
      mode_q     <= bus.mode;
      on_q       <= bus.on;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Priority: running clear > LCD switched off >
  // vblank entry > pixel strobe.
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    clr_cnt_d  = clr_cnt_q;
    clr_bank_d = clr_bank_q;
    pix_wr     = 1'b0;
    last_pix   = 1'b0;
    ovf_hit    = 1'b0;
    clr_wr     = 1'b0;
    clr_done   = 1'b0;

    unique case (state_q)
      CLEAR: begin
        clr_wr = 1'b1;
        if (clr_cnt_q == AW'(NPIX - 1)) begin
          clr_cnt_d = '0;
          if (clr_bank_q == LAST_CLR_BANK) begin
            clr_done = 1'b1;
            state_d  = IDLE;
          end else begin
            clr_bank_d = 1'b1;
          end
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      IDLE: begin
        if (on_fall) begin
          state_d    = CLEAR;
          clr_cnt_d  = '0;
          clr_bank_d = 1'b0;
        end else if (bus.on && !vblank) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
        end
      end

      default: begin  // ACTIVE, FULL
        if (on_fall) begin
          state_d    = CLEAR;
          clr_cnt_d  = '0;
          clr_bank_d = 1'b0;
        end else if (vblank_rise) begin
          // Frame restart; a short frame is simply abandoned.
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
        end else if (bus.ce && !vblank) begin
          if (state_q == ACTIVE) begin
            pix_wr = 1'b1;
            if (x_last && y_last) begin
              last_pix = 1'b1;
              state_d  = FULL;
              x_d      = '0;
              y_d      = '0;
              base_d   = '0;
            end else if (x_last) begin
              x_d    = '0;
              y_d    = y_q + YW'(1);
              base_d = base_q + AW'(W);
            end else begin
              x_d = x_q + XW'(1);
            end
          end else begin
            ovf_hit = 1'b1;
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Address and data
  // hold their last value whenever nothing is written.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    clearing_d   = 1'b0;
    frame_done_d = last_pix;
    overflow_d   = overflow_q;
    rd_bank_d    = rd_bank_q;

    if (clr_wr) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = {clr_bank_q, clr_cnt_q};
      wr_data_d  = CLEAR_VALUE;
      clearing_d = 1'b1;
    end else if (pix_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {wr_bank, base_q + AW'(x_q)};
      wr_data_d = bus.pix_data;
    end

    if (on_rise) begin
      overflow_d = 1'b0;
    end else if (ovf_hit) begin
      overflow_d = 1'b1;
    end

`ifdef LCD_DOUBLE_BUF_EN
    if (clr_done) begin
      rd_bank_d = 1'b0;
    end else if (frame_done_q) begin
      rd_bank_d = ~rd_bank_q;
    end
`else
    rd_bank_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_bank_q    <= 1'b0;
      clearing_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_bank_q    <= rd_bank_d;
      clearing_q   <= clearing_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.clearing   = clearing_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_lcd_vbuf_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_vbuf_writer
//   Directed scenarios plus a randomized stretch for lcd_vbuf_writer with a
//   4x3 frame. A behavioural model (pixel count per frame, clear progress,
//   bank) predicts every output each cycle; a few literal expectations pin
//   the model. Inputs change 2 time units after the rising edge; outputs are
//   compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_vbuf_writer;

  localparam int          W       = 4;
  localparam int          H       = 3;
  localparam int          NPIX    = W * H;
  localparam logic [14:0] CLR_VAL = 15'h0000;
`ifdef LCD_DOUBLE_BUF_EN
  localparam bit          DBUF    = 1'b1;
`else
  localparam bit          DBUF    = 1'b0;
`endif
  localparam int          NCLR    = DBUF ? 2 * NPIX : NPIX;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_CLR  = 2;

  logic clk;
  logic reset_n;
  lcd_vbuf_writer_if bus ();

  lcd_vbuf_writer #(
    .W           (W),
    .H           (H),
    .CLEAR_VALUE (CLR_VAL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;
  int          m_count;     // pixels written in the current frame
  int          m_clr_idx;   // clear writes already issued
  bit          m_rd;
  bit          m_on_q;
  logic [1:0]  m_mode_q;
  logic        exp_en, exp_rb, exp_cl, exp_fd, exp_ov;
  logic [15:0] exp_addr;
  logic [14:0] exp_data;

  task automatic model_reset();
    m_phase = PH_IDLE; m_count = 0; m_clr_idx = 0; m_rd = 1'b0;
    m_on_q = 1'b0; m_mode_q = 2'b00;
    exp_en = 1'b0; exp_addr = '0; exp_data = '0;
    exp_rb = 1'b0; exp_cl = 1'b0; exp_fd = 1'b0; exp_ov = 1'b0;
  endtask

  // Predicts the outputs that follow the next rising edge.
  task automatic model_step();
    logic vb, vb_rise, on_fall, on_rise, old_fd, clr_done;
    vb      = (bus.mode == 2'b01);
    vb_rise = vb && (m_mode_q != 2'b01);
    on_fall = m_on_q && !bus.on;
    on_rise = bus.on && !m_on_q;
    old_fd  = exp_fd;
    clr_done = 1'b0;
    exp_en = 1'b0; exp_cl = 1'b0; exp_fd = 1'b0;

    if (m_phase == PH_CLR) begin
      exp_en   = 1'b1;
      exp_cl   = 1'b1;
      exp_addr = {1'(m_clr_idx / NPIX), 15'(m_clr_idx % NPIX)};
      exp_data = CLR_VAL;
      m_clr_idx++;
      if (m_clr_idx == NCLR) begin
        m_phase  = PH_IDLE;
        clr_done = 1'b1;
      end
    end else if (on_fall) begin
      m_phase   = PH_CLR;
      m_clr_idx = 0;
    end else if (m_phase == PH_IDLE) begin
      if (bus.on && !vb) begin
        m_phase = PH_RUN;
        m_count = 0;
      end
    end else if (vb_rise) begin
      m_count = 0;
    end else if (bus.ce && !vb) begin
      if (m_count < NPIX) begin
        exp_en   = 1'b1;
        exp_addr = {DBUF && !m_rd, 15'(m_count)};
        exp_data = bus.pix_data;
        m_count++;
        if (m_count == NPIX) exp_fd = 1'b1;
      end else begin
        exp_ov = 1'b1;
      end
    end

    if (on_rise) exp_ov = 1'b0;
    if (clr_done) m_rd = 1'b0;
    else if (old_fd && DBUF) m_rd = !m_rd;
    exp_rb   = m_rd;
    m_on_q   = bus.on;
    m_mode_q = bus.mode;
  endtask

  function automatic logic [35:0] dut_vec();
    return {bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_bank,
            bus.clearing, bus.frame_done, bus.overflow};
  endfunction

  // Observation counters taken from the DUT for the literal checks.
  int n_fd_seen  = 0;
  int n_pix_wr   = 0;
  int n_clr_wr   = 0;

  always @(negedge clk) begin
    if (!reset_n) model_reset();
    check("cycle_outputs", dut_vec(),
          {exp_en, exp_addr, exp_data, exp_rb, exp_cl, exp_fd, exp_ov});
    if (bus.frame_done === 1'b1) n_fd_seen++;
    if (bus.wr_en === 1'b1 && bus.clearing === 1'b1) n_clr_wr++;
    if (bus.wr_en === 1'b1 && bus.clearing === 1'b0) n_pix_wr++;
    if (reset_n) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic c, input logic [14:0] d, input logic [1:0] m, input logic o);
    bus.ce = c; bus.pix_data = d; bus.mode = m; bus.on = o;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [1:0] m, input logic o);
    repeat (n) step(1'b0, 15'h0, m, o);
  endtask

  initial begin
    int  fd0, pw0, cw0;
    bit  found;
    logic       cur_on;
    logic [1:0] cur_mode;

    reset_n = 1'b0;
    bus.ce = 1'b0; bus.pix_data = '0; bus.mode = 2'b00; bus.on = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", dut_vec(), 36'h0);
    reset_n = 1'b1;
    idle(2, 2'b00, 1'b0);

    // Full frame, data 1..12
    step(1'b0, 15'h0, 2'b11, 1'b1);
    fd0 = n_fd_seen; pw0 = n_pix_wr;
    for (int k = 1; k <= NPIX; k++) begin
      step(1'b1, 15'(k), 2'b11, 1'b1);
      if (k == 1)
        check("first_write", {bus.wr_en, bus.wr_addr[14:0], bus.wr_data}, {1'b1, 15'd0, 15'd1});
      if (k == NPIX)
        check("last_write", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done},
              {1'b1, DBUF, 15'd11, 15'd12, 1'b1});
    end
    idle(2, 2'b11, 1'b1);
    check("frame_pix_writes", n_pix_wr - pw0, NPIX);
    check("frame_done_count", n_fd_seen - fd0, 1);
    check("no_overflow", bus.overflow, 1'b0);
    check("rd_bank_after_frame", bus.rd_bank, DBUF);

    // Overflow
    step(1'b1, 15'd13, 2'b11, 1'b1);
    check("overflow_no_write", {bus.wr_en, bus.overflow}, 2'b01);
    idle(3, 2'b01, 1'b1);
    check("overflow_sticky_vblank", bus.overflow, 1'b1);

    // LCD off -> clear; strobes during the clear are dropped
    cw0 = n_clr_wr; pw0 = n_pix_wr;
    step(1'b1, 15'h7, 2'b11, 1'b0);
    step(1'b1, 15'h8, 2'b11, 1'b0);
    check("clear_first", {bus.wr_en, bus.clearing, bus.wr_addr, bus.wr_data},
          {1'b1, 1'b1, 16'h0000, CLR_VAL});
    for (int i = 0; i < NCLR + 2; i++) step(1'b1, 15'(i + 20), 2'b11, 1'b0);
    idle(1, 2'b11, 1'b0);
    check("clear_writes", n_clr_wr - cw0, NCLR);
    check("no_pix_during_clear", n_pix_wr - pw0, 0);
    check("idle_after_clear", {bus.wr_en, bus.clearing, bus.rd_bank}, 3'b000);
    check("addr_held_after_clear", bus.wr_addr, {DBUF, 15'(NPIX - 1)});
    check("overflow_through_clear", bus.overflow, 1'b1);
    step(1'b0, 15'h0, 2'b01, 1'b1);
    check("overflow_cleared_on_rise", bus.overflow, 1'b0);

    // Short frame then vblank restart
    step(1'b0, 15'h0, 2'b11, 1'b1);
    fd0 = n_fd_seen;
    for (int k = 0; k < 5; k++) step(1'b1, 15'(100 + k), 2'b11, 1'b1);
    idle(2, 2'b01, 1'b1);
    for (int k = 0; k < NPIX; k++) begin
      step(1'b1, 15'(200 + k), 2'b10, 1'b1);
      if (k == 0)
        check("restart_addr0", {bus.wr_en, bus.wr_addr[14:0]}, {1'b1, 15'd0});
    end
    idle(2, 2'b11, 1'b1);
    check("short_frame_one_done", n_fd_seen - fd0, 1);
    check("rd_bank_after_second_frame", bus.rd_bank, DBUF);

    // Async reset in the middle of a clear
    step(1'b0, 15'h0, 2'b11, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.clearing === 1'b1 && bus.wr_addr === 16'd5) found = 1'b1;
      else step(1'b0, 15'h0, 2'b11, 1'b0);
    end
    check("clear_reached_addr5", found, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", dut_vec(), 36'h0);
    idle(2, 2'b11, 1'b0);
    reset_n = 1'b1;
    idle(1, 2'b11, 1'b0);
    step(1'b0, 15'h0, 2'b11, 1'b1);
    step(1'b1, 15'h55, 2'b11, 1'b1);
    check("post_reset_first_write", {bus.wr_en, bus.wr_addr, bus.wr_data},
          {1'b1, DBUF, 15'd0, 15'h55});

    // Randomized traffic against the model
    fd0 = n_fd_seen; cw0 = n_clr_wr;
    cur_on = 1'b1; cur_mode = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) cur_on = !cur_on;
      if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), 15'($urandom), cur_mode, cur_on);
    end
    idle(NCLR + 4, 2'b11, 1'b1);
    check("random_saw_frames", (n_fd_seen - fd0) > 0, 1'b1);
    check("random_saw_clears", (n_clr_wr - cw0) > 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
